// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the debounce bank and its per-channel filter.
package debounce_pkg;

    localparam int unsigned DB_STABLE_DEFAULT = 256;
    localparam int unsigned DB_SYNC_DEFAULT   = 2;

    // Smallest w such that 2**w >= value; used to size the stability counters.
    function automatic int unsigned db_clog2(input int unsigned value);
        int unsigned     w;
        longint unsigned span;
        w    = 0;
        span = 64'd1;
        while (span < 64'(value)) begin
            span = span << 1;
            w    = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/debounce_bank_if.sv
// Sample-enable, raw inputs and debounced results of a debounce bank.
interface debounce_bank_if #(
    parameter int unsigned CHANNELS = 4
);

    logic                tick;
    logic [CHANNELS-1:0] in;
    logic [CHANNELS-1:0] out;
    logic [CHANNELS-1:0] rise;
    logic [CHANNELS-1:0] fall;
    logic                any_change;

    modport master (
        output tick,
        output in,
        input  out,
        input  rise,
        input  fall,
        input  any_change
    );

    modport slave (
        input  tick,
        input  in,
        output out,
        output rise,
        output fall,
        output any_change
    );

endinterface

// File: rtl/debounce_channel.sv
// One debounced bit: synchroniser chain, tick-gated stability counter, level and edge pulses.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = DB_STABLE_DEFAULT,
    parameter int unsigned SYNC_STAGES   = DB_SYNC_DEFAULT,
    parameter logic        RESET_LEVEL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic din,
    output logic out,
    output logic rise,
    output logic fall
);

    localparam int unsigned   CW       = db_clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          cnt_d;
    logic                   out_d;
    logic                   rise_d;
    logic                   fall_d;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    // Any return of s to the current level wipes the count; no partial credit.
    always_comb begin
        cnt_d  = cnt_q;
        out_d  = out;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (s == out) begin
            cnt_d = '0;
        end else if (tick) begin
            if (cnt_q == CNT_LAST) begin
                out_d  = s;
                cnt_d  = '0;
                rise_d = s;
                fall_d = ~s;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RESET_LEVEL}};
            cnt_q  <= '0;
            out    <= RESET_LEVEL;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            cnt_q  <= cnt_d;
            out    <= out_d;
            rise   <= rise_d;
            fall   <= fall_d;
        end
    end

endmodule

// File: rtl/debounce_bank.sv
// Bank of independent debounced inputs with a shared sample tick and an any-edge summary.
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int unsigned CHANNELS      = 4,
    parameter int unsigned STABLE_CYCLES = DB_STABLE_DEFAULT,
    parameter int unsigned SYNC_STAGES   = DB_SYNC_DEFAULT,
    parameter logic        RESET_LEVEL   = 1'b0
) (
    input logic            clk,
    input logic            rst_n,
    debounce_bank_if.slave bus
);

    logic [CHANNELS-1:0] out_w;
    logic [CHANNELS-1:0] rise_w;
    logic [CHANNELS-1:0] fall_w;

    for (genvar g = 0; g < int'(CHANNELS); g++) begin : g_ch
        debounce_channel #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .SYNC_STAGES   (SYNC_STAGES),
            .RESET_LEVEL   (RESET_LEVEL)
        ) u_ch (
            .clk   (clk),
            .rst_n (rst_n),
            .tick  (bus.tick),
            .din   (bus.in[g]),
            .out   (out_w[g]),
            .rise  (rise_w[g]),
            .fall  (fall_w[g])
        );
    end

    assign bus.out        = out_w;
    assign bus.rise       = rise_w;
    assign bus.fall       = fall_w;
    // Built only from registered pulses, so it is glitch-free within the cycle.
    assign bus.any_change = |(rise_w | fall_w);

endmodule

// File: tb/tb_debounce_bank.sv
// Self-checking bench: vector table, multi-cycle corner sequences and a random run against a run-length model.
module tb_debounce_bank;

    localparam int unsigned NCH  = 4;
    localparam int unsigned STAB = 8;
    localparam int unsigned SYNC = 2;

    logic clk;
    logic rst_n;
    logic rst2_n;
    int   n_checks;
    int   n_fail;
    bit   model_en;

    debounce_bank_if #(.CHANNELS(NCH)) bus ();
    debounce_bank_if #(.CHANNELS(NCH)) bus2 ();

    debounce_bank #(
        .CHANNELS(NCH), .STABLE_CYCLES(STAB), .SYNC_STAGES(SYNC), .RESET_LEVEL(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    debounce_bank #(
        .CHANNELS(NCH), .STABLE_CYCLES(1), .SYNC_STAGES(SYNC), .RESET_LEVEL(1'b1)
    ) dut2 (
        .clk(clk), .rst_n(rst2_n), .bus(bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: the synchronised view is the raw input SYNC samples ago; out flips once
    // that view has disagreed with out for STAB consecutive ticked samples.
    logic [NCH-1:0] hist [SYNC];
    int             run [NCH];
    logic [NCH-1:0] m_out, m_rise, m_fall;

    always @(posedge clk or negedge rst_n) begin
        logic [NCH-1:0] seen, n_out, n_rise, n_fall;
        int             r [NCH];
        if (!rst_n) begin
            for (int i = 0; i < int'(SYNC); i++) hist[i] <= '0;
            for (int c = 0; c < int'(NCH); c++) run[c] <= 0;
            m_out  <= '0;
            m_rise <= '0;
            m_fall <= '0;
        end else begin
            seen   = hist[SYNC-1];
            n_out  = m_out;
            n_rise = '0;
            n_fall = '0;
            r      = run;
            for (int c = 0; c < int'(NCH); c++) begin
                if (seen[c] == m_out[c]) r[c] = 0;
                else if (bus.tick) begin
                    r[c] = r[c] + 1;
                    if (r[c] == int'(STAB)) begin
                        n_out[c] = seen[c];
                        if (seen[c]) n_rise[c] = 1'b1;
                        else n_fall[c] = 1'b1;
                        r[c] = 0;
                    end
                end
            end
            for (int i = int'(SYNC) - 1; i > 0; i--) hist[i] <= hist[i-1];
            hist[0] <= bus.in;
            run     <= r;
            m_out   <= n_out;
            m_rise  <= n_rise;
            m_fall  <= n_fall;
        end
    end

    always @(negedge clk) begin
        if (model_en && rst_n) begin
            check("model out", 32'(bus.out), 32'(m_out));
            check("model rise", 32'(bus.rise), 32'(m_rise));
            check("model fall", 32'(bus.fall), 32'(m_fall));
            check("model any_change", 32'(bus.any_change), 32'(|(m_rise | m_fall)));
        end
    end

    typedef struct {
        logic [NCH-1:0] din;
        int             edges;
        logic [NCH-1:0] exp_out;
        logic [NCH-1:0] exp_rise;
        logic [NCH-1:0] exp_fall;
    } row_t;

    row_t rows [14];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Single rise, 5-cycle glitch then real rise, then simultaneous rise/fall on all channels.
        rows[0]  = '{4'b0001, 9,  4'b0000, 4'b0000, 4'b0000};
        rows[1]  = '{4'b0001, 1,  4'b0001, 4'b0001, 4'b0000};
        rows[2]  = '{4'b0001, 1,  4'b0001, 4'b0000, 4'b0000};
        rows[3]  = '{4'b0011, 5,  4'b0001, 4'b0000, 4'b0000};
        rows[4]  = '{4'b0001, 5,  4'b0001, 4'b0000, 4'b0000};
        rows[5]  = '{4'b0011, 9,  4'b0001, 4'b0000, 4'b0000};
        rows[6]  = '{4'b0011, 1,  4'b0011, 4'b0010, 4'b0000};
        rows[7]  = '{4'b0011, 10, 4'b0011, 4'b0000, 4'b0000};
        rows[8]  = '{4'b1111, 9,  4'b0011, 4'b0000, 4'b0000};
        rows[9]  = '{4'b1111, 1,  4'b1111, 4'b1100, 4'b0000};
        rows[10] = '{4'b1111, 1,  4'b1111, 4'b0000, 4'b0000};
        rows[11] = '{4'b0000, 9,  4'b1111, 4'b0000, 4'b0000};
        rows[12] = '{4'b0000, 1,  4'b0000, 4'b0000, 4'b1111};
        rows[13] = '{4'b0000, 1,  4'b0000, 4'b0000, 4'b0000};

        n_checks  = 0;
        n_fail    = 0;
        model_en  = 1'b0;
        rst_n     = 1'b0;
        rst2_n    = 1'b0;
        bus.in    = '0;
        bus.tick  = 1'b1;
        bus2.in   = 4'b1110;
        bus2.tick = 1'b1;

        #12;
        check("reset out", 32'(bus.out), 32'h0);
        check("reset rise", 32'(bus.rise), 32'h0);
        check("reset fall", 32'(bus.fall), 32'h0);
        check("reset any_change", 32'(bus.any_change), 32'h0);
        check("reset out level1", 32'(bus2.out), 32'hf);

        // RESET_LEVEL=1, STABLE_CYCLES=1: out[0] falls on edge 3.
        @(negedge clk);
        rst2_n = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("lvl1 edge2 out", 32'(bus2.out), 32'hf);
        check("lvl1 edge2 fall", 32'(bus2.fall), 32'h0);
        @(posedge clk);
        @(negedge clk);
        check("lvl1 edge3 out", 32'(bus2.out), 32'he);
        check("lvl1 edge3 fall", 32'(bus2.fall), 32'h1);
        check("lvl1 edge3 rise", 32'(bus2.rise), 32'h0);
        check("lvl1 edge3 any", 32'(bus2.any_change), 32'h1);
        @(posedge clk);
        @(negedge clk);
        check("lvl1 edge4 fall", 32'(bus2.fall), 32'h0);
        check("lvl1 edge4 out", 32'(bus2.out), 32'he);

        rst_n    = 1'b1;
        model_en = 1'b1;
        foreach (rows[i]) begin
            bus.in = rows[i].din;
            repeat (rows[i].edges) @(posedge clk);
            @(negedge clk);
            check($sformatf("row%0d out", i), 32'(bus.out), 32'(rows[i].exp_out));
            check($sformatf("row%0d rise", i), 32'(bus.rise), 32'(rows[i].exp_rise));
            check($sformatf("row%0d fall", i), 32'(bus.fall), 32'(rows[i].exp_fall));
            check($sformatf("row%0d any", i), 32'(bus.any_change),
                  32'(|(rows[i].exp_rise | rows[i].exp_fall)));
        end

        // Tick once every 4 clocks: ticked edges 5,9,..,33 complete the count on edge 33.
        bus.in = 4'b0100;
        for (int k = 1; k <= 36; k++) begin
            bus.tick = ((k - 1) % 4 == 0);
            @(posedge clk);
            @(negedge clk);
            if (k == 32) check("slow tick edge32 out", 32'(bus.out), 32'h0);
            if (k == 33) begin
                check("slow tick edge33 out", 32'(bus.out), 32'h4);
                check("slow tick edge33 rise", 32'(bus.rise), 32'h4);
            end
        end
        bus.tick = 1'b1;

        // Reset while channel 3 has counted 5: state clears immediately, full latency after.
        bus.in = 4'b1100;
        repeat (7) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async reset out", 32'(bus.out), 32'h0);
        check("async reset rise", 32'(bus.rise), 32'h0);
        check("async reset fall", 32'(bus.fall), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (9) @(posedge clk);
        @(negedge clk);
        check("post reset edge9 out", 32'(bus.out), 32'h0);
        @(posedge clk);
        @(negedge clk);
        check("post reset edge10 out", 32'(bus.out), 32'hc);
        check("post reset edge10 rise", 32'(bus.rise), 32'hc);

        // Random toggling and ticking, alternating between busy and quiet phases.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic [NCH-1:0] v;
            v = bus.in;
            for (int c = 0; c < int'(NCH); c++) begin
                if ((cyc / 500) % 2 == 0) begin
                    if ($urandom_range(7) == 0) v[c] = ~v[c];
                end else begin
                    if ($urandom_range(31) == 0) v[c] = ~v[c];
                end
            end
            bus.in   = v;
            bus.tick = ($urandom_range(3) != 0);
            @(posedge clk);
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
